vol_dac_mc: RTL
===============

Name: vol_dac_mc

Overview:
- Multi-channel, double-buffered voltage-DAC behavioural model for SAR-ADC modelling. Successor to the single-channel combinational voltage DAC.
- Channel codes are written through a valid/ready port into per-channel input registers.
- A global load strobe (ldac) commits all input registers to the active registers at once.
- Each real-valued output then ramps linearly to its new level over a parametrised settling time. A busy flag and a done pulse report progress.

Parameters:
- DAC_BITS, 8: code width per channel.
- NUM_CH, 4: number of channels (>=1). Localparam CH_W = max(1, $clog2(NUM_CH)).
- DAC_HIGH, 0.9: real, V, reference-p voltage.
- DAC_LOW, 0.0: real, V, reference-n voltage.
- SETTLE_CYCLES, 4: integer >=0, ramp length in clock cycles. 0 means a step update.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  write accepted when wr_valid && wr_ready.
- wr_ch  input  CH_W  target channel index.
- wr_code  input  DAC_BITS  code for the target channel.
- ldac  input  1  commit all input registers to the active registers.
- busy  output  1  settling in progress.
- settle_done  output  1  one-cycle pulse when settling completes.
- ldac_err  output  1  sticky flag: ldac was received while busy.
- active_code  output  NUM_CH*DAC_BITS  active codes; channel c occupies bits [c*DAC_BITS +: DAC_BITS].
- vol_out  output  real [NUM_CH]  per-channel output voltage.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Transfer function: tgt(code) = DAC_LOW + code*(DAC_HIGH-DAC_LOW)/2**DAC_BITS, computed in real arithmetic. Code 0 gives DAC_LOW; full scale gives DAC_HIGH - 1 LSB.
- Reset (rst_n low): clears immediately, independent of clk, including mid-ramp.
  - Input registers = 0; active registers = 0.
  - vol_out[c] = DAC_LOW for every c.
  - busy = 0, settle_done = 0, ldac_err = 0.
  - FSM returns to IDLE.
- wr_ready = !busy (combinational), so it is 1 out of reset.
- Write: on a clk edge with wr_valid && wr_ready, inreg[wr_ch] <= wr_code.
  - wr_ch >= NUM_CH: data is dropped; the handshake still completes.
  - Active registers and vol_out are unaffected by writes.
- FSM states: IDLE, SETTLE.
- IDLE + ldac at edge E0:
  - active <= inreg, sampled before any same-edge write. A write and ldac in the same cycle: the write lands in inreg but is NOT committed.
  - Per channel: start[c] <= vol_out[c], end[c] <= tgt(inreg[c]).
  - SETTLE_CYCLES = 0: vol_out <= end at E0; settle_done = 1 for the following cycle; stay IDLE; busy stays 0.
  - SETTLE_CYCLES > 0: busy <= 1, counter k <= 0, go to SETTLE. vol_out is unchanged at E0.
- SETTLE, at each edge Ek, k = 1..SETTLE_CYCLES:
  - vol_out[c] <= start[c] + (end[c]-start[c])*k/SETTLE_CYCLES.
  - At k = SETTLE_CYCLES, vol_out[c] is assigned exactly end[c] (no accumulated rounding), busy <= 0, settle_done <= 1 for one cycle, return to IDLE.
  - busy is therefore high for exactly SETTLE_CYCLES cycles.
  - Channels whose code did not change hold a constant output.
- ldac while busy: ignored (no re-target, ramp unaffected); ldac_err <= 1, held until reset.
- ldac in the same cycle busy falls (state is SETTLE at that edge): treated as ldac-while-busy.
- ldac on the first IDLE cycle after settle_done: accepted normally.
- active_code changes only at the commit edge E0.

Test Plan:
- Reset/idle: assert rst_n=0 mid-ramp -> immediately all vol_out = 0.0, active_code = 0, busy = 0, wr_ready = 1, ldac_err = 0.
- Basic step, SETTLE_CYCLES=0, 8-bit, 0.9 V, write ch0=128 and ch3=255, pulse ldac -> on the next edge ch0 = 0.45, ch3 = 0.896484375, ch1 = ch2 = 0.0, settle_done for 1 cycle.
- Ramp, SETTLE_CYCLES=4, ch1 from 0 to 128 -> ch1 = 0.1125, 0.225, 0.3375, 0.45 on E1..E4; busy high 4 cycles; settle_done one cycle after E4; wr_ready low during busy.
- Back-pressure and errors: wr_valid held during busy -> no write until wr_ready returns. ldac pulse at E2 -> ignored, ramp still ends at 0.45, ldac_err = 1 until reset.
- Simultaneous write + ldac in IDLE, ch2 inreg=10, write ch2=20 -> active ch2 = 10, vol_out = 0.03515625. A second ldac later commits 20 (0.0703125).
- Out-of-range channel (NUM_CH=3, wr_ch=3) -> handshake completes, no inreg changes, next ldac leaves all vol_out unchanged.

Source files
------------

// File: rtl/vol_dac_mc.sv
// Multi-channel, double-buffered voltage-DAC behavioural model.
// Channel codes are written through a valid/ready port into per-channel input
// registers. A global ldac strobe commits every input register to the active
// registers at once. Each real output then ramps linearly to its new level
// over SETTLE_CYCLES clocks, or steps at once when SETTLE_CYCLES is 0.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   wr_valid/wr_ready write handshake; wr_ready = !busy
//   wr_ch, wr_code    target channel and code (out-of-range channels are dropped)
//   ldac              commit input registers to active registers
//   busy              settling in progress
//   settle_done       one-cycle pulse when settling completes
//   ldac_err          sticky: ldac seen while settling
//   active_code       packed active codes, channel c at [c*DAC_BITS +: DAC_BITS]
//   vol_out           per-channel output voltage
module vol_dac_mc #(
    parameter int  DAC_BITS      = 8,
    parameter int  NUM_CH        = 4,
    parameter real DAC_HIGH      = 0.9,
    parameter real DAC_LOW       = 0.0,
    parameter int  SETTLE_CYCLES = 4,
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [CH_W-1:0]              wr_ch,
    input  logic [DAC_BITS-1:0]          wr_code,
    input  logic                         ldac,
    output logic                         busy,
    output logic                         settle_done,
    output logic                         ldac_err,
    output logic [NUM_CH*DAC_BITS-1:0]   active_code,
    output real                          vol_out [NUM_CH]
);

    localparam int unsigned CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned LAST     = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam real         SC_R     = (SETTLE_CYCLES > 0) ? real'(SETTLE_CYCLES) : 1.0;
    localparam logic [CH_W:0] NUM_CH_W = (CH_W + 1)'(NUM_CH);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [DAC_BITS-1:0] inreg [NUM_CH];
    real                 ramp_start [NUM_CH];
    real                 ramp_end   [NUM_CH];

    logic commit_c;
    logic last_c;
    logic ldac_busy_c;
    logic wr_fire_c;

    // Ideal transfer function: code -> voltage.
    function automatic real tgt(input logic [DAC_BITS-1:0] code);
        return DAC_LOW + real'(code) * (DAC_HIGH - DAC_LOW) / (2.0 ** DAC_BITS);
    endfunction

    assign wr_ready  = !busy;
    assign wr_fire_c = wr_valid && wr_ready && ({1'b0, wr_ch} < NUM_CH_W);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next  = state;
        commit_c    = 1'b0;
        last_c      = 1'b0;
        ldac_busy_c = 1'b0;
        case (state)
            IDLE: begin
                if (ldac) begin
                    commit_c = 1'b1;
                    if (SETTLE_CYCLES > 0) begin
                        state_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                ldac_busy_c = ldac;
                if (cnt == CNT_W'(LAST)) begin
                    last_c     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Input/active registers, ramp datapath and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            busy        <= 1'b0;
            settle_done <= 1'b0;
            ldac_err    <= 1'b0;
            active_code <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                inreg[c]      <= '0;
                ramp_start[c] <= DAC_LOW;
                ramp_end[c]   <= DAC_LOW;
                vol_out[c]    <= DAC_LOW;
            end
        end else begin
            settle_done <= 1'b0;
            if (ldac_busy_c) begin
                ldac_err <= 1'b1;
            end
            // Commit below reads the pre-edge inreg, so a same-cycle write is not committed.
            if (wr_fire_c) begin
                inreg[wr_ch] <= wr_code;
            end
            if (commit_c) begin
                cnt         <= '0;
                busy        <= (SETTLE_CYCLES > 0);
                settle_done <= (SETTLE_CYCLES == 0);
                for (int c = 0; c < NUM_CH; c++) begin
                    active_code[c*DAC_BITS +: DAC_BITS] <= inreg[c];
                    ramp_start[c] <= vol_out[c];
                    ramp_end[c]   <= tgt(inreg[c]);
                    if (SETTLE_CYCLES == 0) begin
                        vol_out[c] <= tgt(inreg[c]);
                    end
                end
            end else if (state == SETTLE) begin
                cnt <= cnt + CNT_W'(1);
                // Final step lands exactly on the target to avoid rounding drift.
                for (int c = 0; c < NUM_CH; c++) begin
                    if (last_c) begin
                        vol_out[c] <= ramp_end[c];
                    end else begin
                        vol_out[c] <= ramp_start[c]
                                    + (ramp_end[c] - ramp_start[c]) * (real'(cnt) + 1.0) / SC_R;
                    end
                end
                if (last_c) begin
                    busy        <= 1'b0;
                    settle_done <= 1'b1;
                end
            end
        end
    end

endmodule
